// File: rtl/iram_loader_pkg.sv
// Processor-wide IRAM geometry and the loader state encoding.
package iram_loader_pkg;
  localparam int IRAM_INS_W  = 21;
  localparam int IRAM_DEPTH  = 52;
  localparam int IRAM_ADDR_W = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } ld_state_e;
endpackage

// File: rtl/iram_word_assembler.sv
// Packs payload bytes MSB-first into instruction words and keeps the running XOR.
module iram_word_assembler
  import iram_loader_pkg::*;
#(
  parameter int INS_W = IRAM_INS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             byte_en_i,
  input  logic [7:0]       byte_i,
  output logic             word_valid_o,
  output logic [INS_W-1:0] word_o,
  output logic             hdr_bad_o,
  output logic [7:0]       csum_o
);
  logic [1:0]  cnt_q;
  logic [15:0] sh_q;
  logic [7:0]  csum_q;

  // Only the top 3 bits of a word's first byte are reserved.
  assign hdr_bad_o    = byte_en_i && (cnt_q == 2'd0) && (|byte_i[7:5]);
  assign word_valid_o = byte_en_i && (cnt_q == 2'd2);
  assign word_o       = INS_W'({sh_q, byte_i});
  assign csum_o       = csum_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      csum_q <= '0;
    end else if (byte_en_i) begin
      sh_q   <= {sh_q[7:0], byte_i};
      cnt_q  <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
      csum_q <= csum_q ^ byte_i;
    end
  end
endmodule

// File: rtl/iram_loader.sv
// Host-byte-stream loader for the instruction RAM; gates core reset on a verified image.
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int DEPTH  = IRAM_DEPTH,
  parameter int INS_W  = IRAM_INS_W,
  parameter int ADDR_W = IRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INS_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cores_hold
);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, n_q;
  logic              wr_en_q, done_q, err_q, hold_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [INS_W-1:0]  wr_data_q;

  logic             fire, enter_hdr, byte_en;
  logic             word_valid, hdr_bad;
  logic [INS_W-1:0] word;
  logic [7:0]       csum;

  assign busy      = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign in_ready  = busy;
  assign fire      = in_valid && in_ready;
  assign enter_hdr = start && !busy;
  assign byte_en   = fire && (state_q == S_DATA);

  iram_word_assembler #(.INS_W(INS_W)) u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (enter_hdr),
    .byte_en_i    (byte_en),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .hdr_bad_o    (hdr_bad),
    .csum_o       (csum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR;
      S_HDR:  if (fire) state_d = (in_data == 8'd0 || in_data > DEPTH_B) ? S_ERR : S_DATA;
      S_DATA: begin
        if (hdr_bad) state_d = S_ERR;
        else if (word_valid && idx_q == n_q - ADDR_W'(1)) state_d = S_CSUM;
      end
      S_CSUM: if (fire) state_d = (in_data == csum) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_en_q <= word_valid;
      if (word_valid) begin
        wr_addr_q <= idx_q;
        wr_data_q <= word;
        idx_q     <= idx_q + ADDR_W'(1);
      end
      if (state_q == S_HDR && fire) n_q <= in_data[ADDR_W-1:0];
      if (enter_hdr) begin
        idx_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        hold_q <= 1'b1;
      end else if (state_d == S_DONE && state_q != S_DONE) begin
        done_q <= 1'b1;
        hold_q <= 1'b0;
      end else if (state_d == S_ERR && state_q != S_ERR) begin
        err_q  <= 1'b1;
        hold_q <= 1'b1;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cores_hold = hold_q;
endmodule
